// File: rtl/packet_gather.sv
// Packet gather: packs up to four beats into one output batch.
// A batch can close early on in_last; a busy output slot holds the batch.
package packet_gather_pkg;

   typedef struct packed {
      logic [7:0] data;
      logic [3:0] tag;
   } packet_t;

endpackage

module packet_gather
   import packet_gather_pkg::*;
#(
   parameter int NUM_PKT = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  packet_t                 in_pkt,
   input  logic                    in_last,
   output packet_t [NUM_PKT-1:0]   packets_out,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [2:0]              out_count
);

   typedef enum logic {
      S_COLLECT,
      S_PEND
   } state_t;

   state_t                 state_q;
   state_t                 state_d;
   packet_t [NUM_PKT-1:0]  coll_q;
   packet_t [NUM_PKT-1:0]  coll_d;
   packet_t [NUM_PKT-1:0]  fill;
   packet_t [NUM_PKT-1:0]  pkts_q;
   packet_t [NUM_PKT-1:0]  pkts_d;
   logic [1:0]             wr_idx_q;
   logic [1:0]             wr_idx_d;
   logic [2:0]             pcnt_q;
   logic [2:0]             pcnt_d;
   logic [2:0]             cnt_q;
   logic [2:0]             cnt_d;
   logic [2:0]             nxt_cnt;
   logic                   ov_q;
   logic                   ov_d;
   logic                   slot_free;
   logic                   accept;
   logic                   done;

   assign in_ready    = rst_n && (state_q == S_COLLECT);
   assign slot_free   = !ov_q || out_ready;
   assign accept      = in_valid && in_ready;
   assign done        = accept && ((wr_idx_q == 2'd3) || in_last);
   assign nxt_cnt     = {1'b0, wr_idx_q} + 3'd1;

   assign packets_out = pkts_q;
   assign out_valid   = ov_q;
   assign out_count   = cnt_q;

   // The buffer is cleared whenever a batch leaves it, so unwritten
   // entries of the next batch are already zero.
   always_comb begin
      state_d  = state_q;
      coll_d   = coll_q;
      wr_idx_d = wr_idx_q;
      pcnt_d   = pcnt_q;
      pkts_d   = pkts_q;
      cnt_d    = cnt_q;
      ov_d     = ov_q;
      fill     = coll_q;
      fill[wr_idx_q] = in_pkt;

      unique case (state_q)
         S_COLLECT: begin
            if (accept) begin
               coll_d = fill;
               if (done) begin
                  wr_idx_d = 2'd0;
                  if (slot_free) begin
                     pkts_d = fill;
                     cnt_d  = nxt_cnt;
                     ov_d   = 1'b1;
                     coll_d = '0;
                  end else begin
                     state_d = S_PEND;
                     pcnt_d  = nxt_cnt;
                  end
               end else begin
                  wr_idx_d = wr_idx_q + 2'd1;
               end
            end
         end
         S_PEND: begin
            if (slot_free) begin
               pkts_d  = coll_q;
               cnt_d   = pcnt_q;
               ov_d    = 1'b1;
               coll_d  = '0;
               state_d = S_COLLECT;
            end
         end
         default: state_d = S_COLLECT;
      endcase

      if (ov_q && out_ready && (ov_d == ov_q) && (pkts_d == pkts_q)
          && (cnt_d == cnt_q) && !(done && slot_free)
          && !(state_q == S_PEND)) begin
         ov_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_COLLECT;
         coll_q   <= '0;
         wr_idx_q <= 2'd0;
         pcnt_q   <= 3'd0;
         pkts_q   <= '0;
         cnt_q    <= 3'd0;
         ov_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         coll_q   <= coll_d;
         wr_idx_q <= wr_idx_d;
         pcnt_q   <= pcnt_d;
         pkts_q   <= pkts_d;
         cnt_q    <= cnt_d;
         ov_q     <= ov_d;
      end
   end

endmodule

// File: doc/packet_gather.md
PACKET_GATHER -- requirements
Module: packet_gather

Interface
REQ-001 SHALL use packet_t = packed struct {data[7:0], tag[3:0]}, 12 bits, data in bits [11:4].
REQ-002 SHALL have parameter NUM_PKT, default 4, fixed at 4: entries per output batch.
REQ-003 clk  input  1  rising-edge clock; one clock only.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 in_valid  input  1  in_pkt holds a valid beat.
REQ-006 in_ready  output  1  block can accept a beat this cycle.
REQ-007 in_pkt  input  packet_t  incoming packet.
REQ-008 in_last  input  1  beat closes the batch early (partial batch).
REQ-009 packets_out  output  packet_t[4]  assembled batch, feeds the downstream per-lane modifier stage.
REQ-010 out_valid  output  1  packets_out/out_count hold a batch.
REQ-011 out_ready  input  1  downstream accepts the batch.
REQ-012 out_count  output  3  number of valid entries, 1..4.

Function
REQ-013 Input transfer SHALL occur on a rising edge with in_valid && in_ready; output transfer on out_valid && out_ready.
REQ-014 Collection buffer SHALL hold 4 packet_t plus write index wr_idx (0..3); an accepted beat SHALL be written to entry wr_idx and wr_idx SHALL increment.
REQ-015 A beat SHALL complete a batch when wr_idx==3 or in_last==1; wr_idx SHALL return to 0 after a completing beat.
REQ-016 On completion, entries after the last written SHALL be zero, and batch count SHALL be wr_idx+1.
REQ-017 Output slot is free in a cycle when out_valid==0 or out_ready==1.
REQ-018 If the slot is free in the completing cycle, the batch SHALL load into packets_out/out_count with out_valid=1 on the next edge (latency 1 cycle from completing beat).
REQ-019 If the slot is not free, a pend flag SHALL set, the batch SHALL stay in the collection buffer, and in_ready SHALL be 0 while pend==1.
REQ-020 While pend==1, on the first cycle the slot is free, the batch SHALL load to the output on that edge and pend SHALL clear; in_ready SHALL be 1 the following cycle.
REQ-021 in_ready SHALL equal rst_n && !pend (combinational); no other condition stalls input.
REQ-022 With out_ready held 1, sustained throughput SHALL be one beat per cycle with no bubbles.
REQ-023 out_valid SHALL drop to 0 after an output transfer unless a new batch loads on the same edge; then it SHALL stay 1 with the new contents.
REQ-024 While out_valid==1 && out_ready==0, packets_out and out_count SHALL remain stable.
REQ-025 in_last on the 4th beat (wr_idx==3) SHALL behave as a normal full batch, out_count=4.
REQ-026 in_valid without in_ready SHALL have no effect; in_pkt/in_last SHALL be ignored when in_valid==0.
REQ-027 No packet_t field SHALL be modified; the block reorders nothing (beat k of a batch goes to entry k).

Reset
REQ-028 On a rising edge with rst_n==0: out_valid=0, out_count=0, packets_out all zero, wr_idx=0, pend=0, collection buffer zero.
REQ-029 Reset mid-batch or mid-stall SHALL discard partial and pending batches; no output SHALL appear for them after reset.
REQ-030 in_ready SHALL be 0 while rst_n==0 and 1 on the first cycle after release.

Verification
REQ-031 Full batch: 4 beats, data 0x10..0x13, tag 0x1..0x4, out_ready=1 -> out_valid one cycle after the 4th beat, packets_out[k]={0x10+k,0x1+k}, out_count=4.
REQ-032 Partial: 2 beats {0xAA,0x5},{0xBB,0x6}, 2nd with in_last -> out_count=2, entries 0-1 match, entries 2-3 = 0.
REQ-033 Back-pressure: out_ready=0, send 8 beats continuously -> first batch held stable, in_ready falls after the 8th beat; raise out_ready -> batch 1 then batch 2 delivered in order, in_ready back to 1.
REQ-034 Streaming: 16 beats back-to-back with out_ready=1 -> 4 batches on consecutive batch boundaries, in_ready never 0.
REQ-035 Reset mid-batch: 3 beats accepted, rst_n=0 one cycle, then 4 new beats -> only the new batch emitted, out_count=4.
REQ-036 Chained with downstream stage: batch {0xFF,0xA} x4 -> downstream packets_out data 0x00, tag 0x0 in every lane.
